hack_rom_loader: RTL and testbench
==================================

# hack_rom_loader

Writer side of the Hack instruction ROM. Receives a program image as a byte stream from the host link (UART receiver or debug bridge) and writes it word-by-word into the 32K×16 instruction memory's write port. Holds the CPU in reset while loading and releases it once the image is complete and valid. Sits between the byte receiver and the ROM32K write port on the top-level board design.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65535: maximum idle cycles between bytes once a load has started; 0 disables the timeout.
- `MAX_WORDS`, default 32768: largest accepted image length in words.

Ports:
- `clock` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; aborts any load and begins a new one.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: write strobe to the ROM write port.
- `mem_addr` out 15: write address.
- `mem_wdata` out 16: write data.
- `cpu_hold` out 1: holds the CPU in reset.
- `done` out 1: image loaded successfully; sticky.
- `error` out 1: load failed; sticky.

## Operation
- Byte transfer happens when `rx_valid && rx_ready`.
- Frame format, all fields big-endian:
  - LEN_HI, LEN_LO: word count N.
  - N × (DATA_HI, DATA_LO).
  - Optional CSUM_HI, CSUM_LO; see Configuration.
- States are IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERROR.
- Reset state is LEN_HI: a load begins immediately after reset with no `start` needed.
- IDLE is entered only from DONE or ERROR after `start` deasserts; leaving it requires `start`.
- `start` in any state:
  - Next state is LEN_HI.
  - Address counter and checksum are cleared.
  - `done` and `error` are cleared.
  - `cpu_hold` is set.
- `rx_ready` is 1 in LEN_*, DATA_* and CSUM_* states, and 0 otherwise.
- After LEN_LO is accepted:
  - N > `MAX_WORDS`: go to ERROR, with no writes.
  - N = 0: go to CSUM_HI if checksum is enabled, otherwise DONE.
  - Otherwise: go to DATA_HI.
- DATA_HI: the byte is latched into the high-byte register.
- DATA_LO accepted:
  - Next cycle: `mem_we` = 1 for exactly one cycle, `mem_wdata` = {hi, lo}, `mem_addr` = current word index.
  - The index increments after the write.
  - The last word (index N−1) moves the FSM to CSUM_HI or DONE.
- Word index is 16 bits internally; `mem_addr` is its low 15 bits. With N ≤ 32768 the address never wraps.
- DONE: `done` = 1, `cpu_hold` = 0, `rx_ready` = 0; extra bytes are not consumed.
- ERROR: `error` = 1, `cpu_hold` = 1, `rx_ready` = 0.
- Timeout applies in every receiving state except LEN_HI: if no byte is accepted for `TIMEOUT_CYCLES` consecutive cycles, go to ERROR.

## Timing
- Reset values: `rx_ready` = 1, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_hold` = 1, `done` = 0, `error` = 0.
- Throughput is one byte per cycle sustained, so back-to-back `rx_valid` is accepted every cycle.
- Write latency: `mem_we` appears 1 cycle after the DATA_LO handshake.
- `done` rises, and `cpu_hold` falls, 1 cycle after the final handshake: the last DATA_LO, or CSUM_LO when checksum is enabled. For the last word, `done` and `mem_we` are asserted in the same cycle.
- `start` coincident with a handshake: `start` wins and the byte is discarded. A `mem_we` already registered for the current cycle still completes.
- Mid-operation `reset_n` assertion: all outputs return to reset values immediately and asynchronously.

## Configuration
- Macro: `HACK_ROM_LOADER_CHECKSUM_EN`.
- Defined:
  - A 16-bit checksum (sum of all data words modulo 2^16, starting at 0) is accumulated.
  - After the data, CSUM_HI and CSUM_LO are received.
  - Match goes to DONE; mismatch goes to ERROR.
  - Memory writes are not rolled back; `cpu_hold` stays 1.
- Undefined: the CSUM states and the accumulator are absent; the frame ends after the data.

## Structure
- Package `hack_loader_pkg` contains:
  - State enum `loader_state_t`.
  - `ROM_ADDR_W` = 15.
  - `ROM_DATA_W` = 16.
  - `ROM_DEPTH` = 32768.
- Sub-module `hack_loader_csum` is the checksum accumulator, with clear, add-enable and word input. It is instantiated only under the macro.

## Test plan
1. After reset, stream 00 02 00 00 EF D0 → writes addr 0 = 0x0000 and addr 1 = 0xEFD0; `done` = 1; `cpu_hold` = 0.
2. Stream 00 00 → `done` 1 cycle after LEN_LO; `mem_we` never asserts.
3. Stream 80 01 → `error` = 1, `cpu_hold` = 1, no writes, `rx_ready` = 0.
4. `rx_valid` toggling with random gaps shorter than `TIMEOUT_CYCLES` → same writes as test 1. With `TIMEOUT_CYCLES` = 16, stall after EF for 16 cycles → `error` = 1.
5. `start` pulse after 3 words of a 5-word load, then a fresh 1-word image E0 10 → single write at addr 0 = 0xE010; `done` = 1.
6. With `HACK_ROM_LOADER_CHECKSUM_EN`, send 00 02 00 01 00 02 00 03 → `done`. Same frame with checksum byte pair 00 04 → `error`, `cpu_hold` = 1.

Source files
------------

// File: rtl/hack_loader_pkg.sv
// Shared definitions for the Hack ROM loader.
//   loader_state_t : loader FSM state encoding
//   ROM_ADDR_W / ROM_DATA_W / ROM_DEPTH : ROM32K write-port geometry
package hack_loader_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 16;
  localparam int ROM_DEPTH  = 32768;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // States in which the loader consumes bytes from the host link.
  function automatic logic is_rx_state(input loader_state_t s);
    return (s == ST_LEN_HI)  || (s == ST_LEN_LO)  ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
           (s == ST_CSUM_HI) || (s == ST_CSUM_LO);
  endfunction

endpackage

// File: rtl/hack_loader_csum.sv
// Image checksum accumulator: 16-bit sum of data words, modulo 2^16.
//   clock, reset_n : system clock, async active-low reset
//   clear_i        : restart the sum at zero (takes priority over add_en_i)
//   add_en_i       : add word_i into the sum this cycle
//   word_i         : data word
//   sum_o          : running sum
module hack_loader_csum
  import hack_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic                  add_en_i,
  input  logic [ROM_DATA_W-1:0] word_i,
  output logic [ROM_DATA_W-1:0] sum_o
);

  logic [ROM_DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i)       sum_d = '0;
    else if (add_en_i) sum_d = sum_q + word_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/hack_rom_loader.sv
// Hack ROM loader: receives a big-endian program image (LEN, N data words,
// optional checksum) over a byte stream, writes it into the ROM32K write
// port and holds the CPU in reset until the image is complete and valid.
// Optional feature macro: HACK_ROM_LOADER_CHECKSUM_EN (trailing checksum).
//   clock, reset_n       : system clock, async active-low reset
//   start                : abort any load and begin a new one
//   rx_data/valid/ready  : byte stream handshake
//   mem_we/addr/wdata    : ROM write port
//   cpu_hold             : CPU reset hold
//   done / error         : sticky load status
//
// state    | meaning
// IDLE     | finished, waiting for start
// LEN_HI   | waiting for word-count high byte (no timeout)
// LEN_LO   | waiting for word-count low byte
// DATA_HI  | waiting for data word high byte
// DATA_LO  | waiting for data word low byte, then write
// CSUM_HI  | waiting for checksum high byte
// CSUM_LO  | waiting for checksum low byte, then compare
// DONE     | image loaded, CPU released
// ERROR    | load failed, CPU held
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_WORDS      = ROM_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ROM_ADDR_W-1:0] mem_addr,
  output logic [ROM_DATA_W-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  // Down-counter reload: reaching zero with one more idle cycle means
  // TIMEOUT_CYCLES consecutive idle cycles have elapsed.
  localparam logic [31:0] TMO_LOAD = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  loader_state_t         state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  mem_we_q, mem_we_d;
  logic [ROM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ROM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  go_done, go_error;

  logic                  hs;
  logic [15:0]           word_w;

  assign rx_ready = is_rx_state(state_q);
  assign hs       = rx_valid && rx_ready;
  assign word_w   = {hi_q, rx_data};

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  logic [ROM_DATA_W-1:0] csum_sum;

  hack_loader_csum u_csum (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (start),
    .add_en_i (hs && !start && (state_q == ST_DATA_LO)),
    .word_i   (word_w),
    .sum_o    (csum_sum)
  );
`endif

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    done_d      = done_q;
    error_d     = error_q;
    go_done     = 1'b0;
    go_error    = 1'b0;

    if (start) begin
      // Any byte handshaking this cycle is dropped.
      state_d = ST_LEN_HI;
      idx_d   = '0;
      tmo_d   = TMO_LOAD;
      hold_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      if (hs) begin
        tmo_d = TMO_LOAD;
      end else if (TMO_EN && rx_ready && (state_q != ST_LEN_HI)) begin
        if (tmo_q == '0) go_error = 1'b1;
        else             tmo_d = tmo_q - 32'd1;
      end

      unique case (state_q)
        ST_LEN_HI: if (hs) begin
          hi_d    = rx_data;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: if (hs) begin
          len_d = word_w;
          if ({16'd0, word_w} > MAX_WORDS) go_error = 1'b1;
          else if (word_w == '0) begin
            if (CSUM_EN) state_d = ST_CSUM_HI;
            else         go_done = 1'b1;
          end else state_d = ST_DATA_HI;
        end
        ST_DATA_HI: if (hs) begin
          hi_d    = rx_data;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ROM_ADDR_W-1:0];
          mem_wdata_d = word_w;
          idx_d       = idx_q + 16'd1;
          if (idx_q == len_q - 16'd1) begin
            if (CSUM_EN) state_d = ST_CSUM_HI;
            else         go_done = 1'b1;
          end else state_d = ST_DATA_HI;
        end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        ST_CSUM_HI: if (hs) begin
          hi_d    = rx_data;
          state_d = ST_CSUM_LO;
        end
        ST_CSUM_LO: if (hs) begin
          if (word_w == csum_sum) go_done  = 1'b1;
          else                    go_error = 1'b1;
        end
`endif
        ST_DONE, ST_ERROR: state_d = ST_IDLE;
        default: ;
      endcase

      if (go_error) begin
        state_d = ST_ERROR;
        error_d = 1'b1;
        hold_d  = 1'b1;
      end else if (go_done) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        hold_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LEN_HI;
      hi_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= TMO_LOAD;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
module tb_hack_rom_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] img_q[$];
  logic [7:0]  frame_q[$];
  logic [14:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [14:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  hack_rom_loader #(.TIMEOUT_CYCLES(16), .MAX_WORDS(32768)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  // Write-port monitor
  always @(negedge clock) begin
    if (reset_n && mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame bytes and expected writes from the word list.
  task automatic build_frame();
    logic [15:0] n, sum;
    n = 16'(img_q.size());
    sum = '0;
    frame_q = {};
    exp_addr_q = {};
    exp_data_q = {};
    frame_q.push_back(n[15:8]);
    frame_q.push_back(n[7:0]);
    foreach (img_q[i]) begin
      frame_q.push_back(img_q[i][15:8]);
      frame_q.push_back(img_q[i][7:0]);
      exp_addr_q.push_back(15'(i));
      exp_data_q.push_back(img_q[i]);
      sum = sum + img_q[i];
    end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    frame_q.push_back(sum[15:8]);
    frame_q.push_back(sum[7:0]);
`else
    if (sum == 16'hFFFF) sum = '0;
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic accepted;
    accepted = 1'b0;
    repeat (gap) @(posedge clock);
    if (gap > 0) #1;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 40 && !accepted; k++) begin
      @(negedge clock);
      accepted = rx_ready;
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
    chk("handshake", {31'd0, accepted}, 32'd1);
  endtask

  task automatic send_frame(input int gap_max);
    foreach (frame_q[i])
      send_byte(frame_q[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wr_addr_q = {};
    wr_data_q = {};
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, wr_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, {17'd0, wr_addr_q[i]}, {17'd0, exp_addr_q[i]});
      chk({tag, "_wr_data"}, {16'd0, wr_data_q[i]}, {16'd0, exp_data_q[i]});
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Test 1: load straight out of reset, no start needed
    img_q = {16'h0000, 16'hEFD0};
    build_frame();
    send_frame(0);
`ifndef HACK_ROM_LOADER_CHECKSUM_EN
    chk("t1_last_we", {31'd0, mem_we}, 32'd1);
    chk("t1_last_addr", {17'd0, mem_addr}, 32'd1);
    chk("t1_last_data", {16'd0, mem_wdata}, 32'hEFD0);
`endif
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    @(posedge clock);
    #1;
    check_writes("t1");
    // Extra bytes after DONE are not consumed
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("t1_extra_ready", {31'd0, rx_ready}, 32'd0);
    chk("t1_extra_done", {31'd0, done}, 32'd1);
    rx_valid = 1'b0;
    check_writes("t1_extra");

    // Asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arst_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Test 2: empty image
    pulse_start();
    img_q = {};
    build_frame();
    send_frame(0);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check_writes("t2");

    // Test 3: oversize length
    pulse_start();
    chk("t3_start_clears_done", {31'd0, done}, 32'd0);
    chk("t3_start_sets_hold", {31'd0, cpu_hold}, 32'd1);
    frame_q = {8'h80, 8'h01};
    exp_addr_q = {};
    exp_data_q = {};
    send_frame(0);
    chk("t3_error", {31'd0, error}, 32'd1);
    chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t3_ready", {31'd0, rx_ready}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check_writes("t3");

    // Boundary: exactly MAX_WORDS is accepted
    pulse_start();
    chk("t3b_start_clears_error", {31'd0, error}, 32'd0);
    frame_q = {8'h80, 8'h00};
    send_frame(0);
    chk("t3b_error", {31'd0, error}, 32'd0);
    chk("t3b_ready", {31'd0, rx_ready}, 32'd1);

    // Test 4a: random gaps below the timeout
    pulse_start();
    img_q = {16'h0000, 16'hEFD0};
    build_frame();
    send_frame(12);
    chk("t4_done", {31'd0, done}, 32'd1);
    @(posedge clock);
    #1;
    check_writes("t4");

    // Test 4b: stall after EF for 16 idle cycles
    pulse_start();
    frame_q = {8'h00, 8'h02, 8'h00, 8'h00, 8'hEF};
    send_frame(0);
    repeat (15) @(posedge clock);
    #1;
    chk("t4_tmo_15", {31'd0, error}, 32'd0);
    @(posedge clock);
    #1;
    chk("t4_tmo_16", {31'd0, error}, 32'd1);
    chk("t4_tmo_ready", {31'd0, rx_ready}, 32'd0);
    chk("t4_tmo_hold", {31'd0, cpu_hold}, 32'd1);

    // Test 5: abort a 5-word load after 3 words, start coincident with a byte
    pulse_start();
    frame_q = {8'h00, 8'h05, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    send_frame(0);
    rx_data = 8'h12;
    rx_valid = 1'b1;
    pulse_start();
    rx_valid = 1'b0;
    chk("t5_abort_we", {31'd0, mem_we}, 32'd0);
    chk("t5_abort_hold", {31'd0, cpu_hold}, 32'd1);
    img_q = {16'hE010};
    build_frame();
    send_frame(0);
    chk("t5_done", {31'd0, done}, 32'd1);
    @(posedge clock);
    #1;
    check_writes("t5");

    // Randomized images against the model
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      img_q = {};
      for (int w = 0; w < int'($urandom_range(6, 1)); w++)
        img_q.push_back(16'($urandom));
      build_frame();
      send_frame((r % 2 == 0) ? 0 : 12);
      chk("rnd_done", {31'd0, done}, 32'd1);
      chk("rnd_error", {31'd0, error}, 32'd0);
      @(posedge clock);
      #1;
      check_writes("rnd");
    end

    // Randomized oversize length
    pulse_start();
    begin
      logic [15:0] n;
      n = 16'($urandom_range(65535, 32769));
      frame_q = {n[15:8], n[7:0]};
    end
    exp_addr_q = {};
    exp_data_q = {};
    send_frame(0);
    chk("rnd_big_error", {31'd0, error}, 32'd1);
    @(posedge clock);
    #1;
    check_writes("rnd_big");

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    // Test 6: checksum match and mismatch
    pulse_start();
    img_q = {16'h0001, 16'h0002};
    build_frame();
    send_frame(0);
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
    check_writes("t6");
    pulse_start();
    build_frame();
    frame_q[frame_q.size() - 1] = 8'h04;
    send_frame(0);
    chk("t6_bad_error", {31'd0, error}, 32'd1);
    chk("t6_bad_done", {31'd0, done}, 32'd0);
    chk("t6_bad_hold", {31'd0, cpu_hold}, 32'd1);
    check_writes("t6_bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
